// File: rtl/hold_grab_detector.sv
// Sequential hold-table scanner: reports the lowest-index enabled hold whose
// WIDTH x HEIGHT rectangle contains the latched world-space query point.
module hold_grab_detector #(
    parameter int WIDTH     = 48,
    parameter int HEIGHT    = 20,
    parameter int NUM_HOLDS = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [10:0]          query_x,
    input  logic signed [11:0]          query_y,
    output logic        [ADDR_BITS-1:0] hold_addr,
    input  logic signed [10:0]          hold_x,
    input  logic signed [11:0]          hold_y,
    input  logic                        hold_en,
    output logic                        busy,
    output logic                        done,
    output logic                        hit,
    output logic        [ADDR_BITS-1:0] hit_index
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic        [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_HOLDS - 1);
    localparam logic signed [11:0]          W_EXT    = 12'(WIDTH);
    localparam logic signed [12:0]          H_EXT    = 13'(HEIGHT);

    logic        [1:0]           state;
    logic        [ADDR_BITS-1:0] idx;
    logic signed [10:0]          qx_p0;
    logic signed [11:0]          qy_p0;
    logic                        in_rect;

    // Widen by one bit before adding the extent so holds near +1023/+2047 do not wrap.
    function automatic logic contains(
        input logic signed [10:0] hx,
        input logic signed [11:0] hy,
        input logic signed [10:0] px,
        input logic signed [11:0] py
    );
        logic signed [11:0] hx_e, px_e, hx_end;
        logic signed [12:0] hy_e, py_e, hy_end;
        hx_e   = {hx[10], hx};
        px_e   = {px[10], px};
        hy_e   = {hy[11], hy};
        py_e   = {py[11], py};
        hx_end = hx_e + W_EXT;
        hy_end = hy_e + H_EXT;
        return (px_e >= hx_e) && (px_e < hx_end) && (py_e >= hy_e) && (py_e < hy_end);
    endfunction

    assign in_rect   = hold_en && contains(hold_x, hold_y, qx_p0, qy_p0);
    assign hold_addr = idx;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            qx_p0     <= '0;
            qy_p0     <= '0;
            hit       <= 1'b0;
            hit_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        qx_p0 <= query_x;
                        qy_p0 <= query_y;
                        idx   <= '0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: state <= S_CMP;
                // Table data now reflects idx; first hit ends the scan early.
                S_CMP: begin
                    if (in_rect) begin
                        hit       <= 1'b1;
                        hit_index <= idx;
                        state     <= S_DONE;
                    end else if (idx == LAST_IDX) begin
                        hit       <= 1'b0;
                        hit_index <= '0;
                        state     <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_ADDR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hold_grab_detector.sv
// Bench for hold_grab_detector: synchronous-read table model, timeline-level
// reference model checked every cycle, plus literal checks of key scenarios.
module tb_hold_grab_detector;

    localparam int N = 16;

    logic               clock, reset, start;
    logic signed [10:0] query_x, hold_x;
    logic signed [11:0] query_y, hold_y;
    logic               hold_en;
    logic        [3:0]  hold_addr, hit_index;
    logic               busy, done, hit;

    logic signed [10:0] tbl_x  [N];
    logic signed [11:0] tbl_y  [N];
    logic               tbl_en [N];

    int n_vec = 0;
    int n_err = 0;

    hold_grab_detector #(.WIDTH(48), .HEIGHT(20), .NUM_HOLDS(N), .ADDR_BITS(4)) dut (
        .clock(clock), .reset(reset), .start(start),
        .query_x(query_x), .query_y(query_y),
        .hold_addr(hold_addr), .hold_x(hold_x), .hold_y(hold_y), .hold_en(hold_en),
        .busy(busy), .done(done), .hit(hit), .hit_index(hit_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read hold table
    always @(posedge clock) begin
        hold_x  <= tbl_x[hold_addr];
        hold_y  <= tbl_y[hold_addr];
        hold_en <= tbl_en[hold_addr];
    end

    // Reference: first containing enabled hold, plain integer arithmetic
    function automatic int first_hit(input int qx, input int qy);
        for (int k = 0; k < N; k++)
            if (tbl_en[k] && int'(tbl_x[k]) <= qx && qx < int'(tbl_x[k]) + 48 &&
                int'(tbl_y[k]) <= qy && qy < int'(tbl_y[k]) + 20)
                return k;
        return -1;
    endfunction

    // Timeline model: d = cycle number within the current scan
    int   m_d = 0, m_len = 0, m_fin = 0, m_idx = 0, m_addr = 0, r_idx = 0;
    logic m_active = 0, m_busy = 0, m_done = 0, m_hit = 0, r_hit = 0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_active = 0; m_busy = 0; m_done = 0; m_hit = 0; m_idx = 0; m_addr = 0;
        end else if (m_active) begin
            if (m_d == m_len) begin
                m_active = 0; m_busy = 0; m_done = 0;
            end else begin
                m_d++;
                m_addr = ((m_d - 1) / 2 < m_fin) ? (m_d - 1) / 2 : m_fin;
                if (m_d == m_len) begin
                    m_done = 1; m_hit = r_hit; m_idx = r_idx;
                end
            end
        end else if (start) begin
            int k;
            k        = first_hit(int'(query_x), int'(query_y));
            r_hit    = (k >= 0);
            r_idx    = (k >= 0) ? k : 0;
            m_fin    = (k >= 0) ? k : N - 1;
            m_len    = (k >= 0) ? 2 * k + 3 : 2 * N + 1;
            m_active = 1; m_d = 1; m_busy = 1; m_addr = 0;
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        cmp("busy", int'(busy), int'(m_busy));
        cmp("done", int'(done), int'(m_done));
        cmp("hit", int'(hit), int'(m_hit));
        cmp("hit_index", int'(hit_index), m_idx);
        cmp("hold_addr", int'(hold_addr), m_addr);
    end

    task automatic clear_tbl();
        for (int k = 0; k < N; k++) begin
            tbl_x[k] = '0; tbl_y[k] = '0; tbl_en[k] = 1'b0;
        end
    endtask

    task automatic set_hold(input int k, input int x, input int y, input logic en);
        tbl_x[k] = 11'(x); tbl_y[k] = 12'(y); tbl_en[k] = en;
    endtask

    int res_hit, res_idx, dcyc;

    // Issue a query; optionally pulse start with a different query at cycles p1/p2
    task automatic run_query(input int qx, input int qy, input int p1, input int p2,
                             output int dc);
        @(posedge clock); #1;
        start = 1'b1; query_x = 11'(qx); query_y = 12'(qy);
        @(posedge clock); #1;
        dc = -1;
        for (int c = 1; c < 200; c++) begin
            if (c == p1 || c == p2) begin
                start = 1'b1; query_x = 11'(qx - 300); query_y = 12'(qy + 150);
            end else begin
                start = 1'b0; query_x = 11'(qx); query_y = 12'(qy);
            end
            @(negedge clock);
            if (done) begin
                dc = c; res_hit = int'(hit); res_idx = int'(hit_index);
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        start = 1'b0; query_x = 11'(qx); query_y = 12'(qy);
        if (dc < 0) begin
            n_vec++; n_err++;
            $display("FAIL timeout: no done within 200 cycles (query %0d,%0d)", qx, qy);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (done) cnt++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int cnt;
    int qxs[6] = '{147, 100, 148, 99, 120, 120};
    int qys[6] = '{219, 200, 210, 210, 220, 199};
    int exh[6] = '{1, 1, 0, 0, 0, 0};

    initial begin
        reset = 1'b1; start = 1'b0; query_x = '0; query_y = '0;
        clear_tbl();
        repeat (3) @(posedge clock);
        @(negedge clock);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_hold_addr", int'(hold_addr), 0);
        cmp("rst_hit", int'(hit), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single hold at index 3
        set_hold(3, 100, 200, 1'b1);
        run_query(120, 210, -1, -1, dcyc);
        cmp("single_done_cycle", dcyc, 9);
        cmp("single_hit", res_hit, 1);
        cmp("single_idx", res_idx, 3);

        // Rectangle edges around hold 0
        clear_tbl();
        set_hold(0, 100, 200, 1'b1);
        for (int t = 0; t < 6; t++) begin
            run_query(qxs[t], qys[t], -1, -1, dcyc);
            cmp("edge_done_cycle", dcyc, exh[t] ? 3 : 33);
            cmp("edge_hit", res_hit, exh[t]);
            cmp("edge_idx", res_idx, 0);
        end

        // Overlapping holds: lowest index wins
        clear_tbl();
        set_hold(2, 280, 390, 1'b1);
        set_hold(5, 290, 395, 1'b1);
        run_query(300, 400, -1, -1, dcyc);
        cmp("overlap_idx", res_idx, 2);
        cmp("overlap_done_cycle", dcyc, 7);
        set_hold(2, 280, 390, 1'b0);
        run_query(300, 400, -1, -1, dcyc);
        cmp("overlap_dis_idx", res_idx, 5);
        cmp("overlap_dis_done_cycle", dcyc, 13);

        // Signed extremes
        clear_tbl();
        set_hold(0, -30, -10, 1'b1);
        run_query(-1, 5, -1, -1, dcyc);
        cmp("neg_hit", res_hit, 1);
        set_hold(0, 1000, 2040, 1'b1);
        run_query(1023, 2047, -1, -1, dcyc);
        cmp("max_hit", res_hit, 1);
        set_hold(0, -1024, -2048, 1'b1);
        run_query(1023, 0, -1, -1, dcyc);
        cmp("far_miss", res_hit, 0);
        cmp("far_done_cycle", dcyc, 33);

        // Start pulses during a running scan are ignored
        clear_tbl();
        set_hold(3, 100, 200, 1'b1);
        run_query(120, 210, 4, 9, dcyc);
        cmp("hs_done_cycle", dcyc, 9);
        cmp("hs_idx", res_idx, 3);
        count_dones(20, cnt);
        cmp("hs_extra_done", cnt, 0);

        // Reset in the middle of a miss scan
        @(posedge clock); #1;
        start = 1'b1; query_x = 11'(0); query_y = 12'(0);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        cmp("mid_rst_busy", int'(busy), 0);
        cmp("mid_rst_done", int'(done), 0);
        cmp("mid_rst_hit", int'(hit), 0);
        cmp("mid_rst_idx", int'(hit_index), 0);
        cmp("mid_rst_addr", int'(hold_addr), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        count_dones(40, cnt);
        cmp("post_rst_done", cnt, 0);
        run_query(120, 210, -1, -1, dcyc);
        cmp("post_rst_done_cycle", dcyc, 9);
        cmp("post_rst_idx", res_idx, 3);

        // Randomized tables and queries
        for (int t = 0; t < 60; t++) begin
            int qx, qy;
            clear_tbl();
            for (int k = 0; k < N; k++) begin
                if (t % 5 == 4)
                    set_hold(k, int'($urandom_range(0, 2047)) - 1024,
                             int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 1)));
                else
                    set_hold(k, int'($urandom_range(0, 300)) - 150,
                             int'($urandom_range(0, 200)) - 100, 1'($urandom_range(0, 1)));
            end
            if (t % 5 == 4) begin
                qx = int'($urandom_range(0, 2047)) - 1024;
                qy = int'($urandom_range(0, 4095)) - 2048;
            end else begin
                qx = int'($urandom_range(0, 350)) - 150;
                qy = int'($urandom_range(0, 220)) - 100;
            end
            run_query(qx, qy, -1, -1, dcyc);
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hold_grab_detector.md
# hold_grab_detector

Reverse-direction companion to the per-pixel hold renderer: instead of asking "does this screen pixel fall on a hold?", it asks "which hold, if any, is under this world-space point?". On a `start` pulse it scans the hold table sequentially for the climber's hand or foot position. It then reports the lowest-index enabled hold whose `WIDTH`×`HEIGHT` rectangle contains that point. Sits between the climber physics/control logic (query side) and the shared hold-position table (synchronous-read memory).

## Interface
- `WIDTH`, 48, hold rectangle width in world pixels (same value the renderer uses)
- `HEIGHT`, 20, hold rectangle height in world pixels
- `NUM_HOLDS`, 16, number of table entries scanned (≥1)
- `ADDR_BITS`, 4, width of table address / hit index; 2^ADDR_BITS ≥ NUM_HOLDS
- `clock`  in  1  sole clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  query request; sampled only in IDLE
- `query_x`  in  signed 11  world x of point under test; latched on accepted start
- `query_y`  in  signed 12  world y of point under test; latched on accepted start
- `hold_addr`  out  ADDR_BITS  table read address (registered)
- `hold_x`  in  signed 11  left edge of addressed hold; valid one cycle after `hold_addr`
- `hold_y`  in  signed 12  top edge of addressed hold; valid one cycle after `hold_addr`
- `hold_en`  in  1  addressed entry is live; same timing as `hold_x`
- `busy`  out  1  scan in progress (ADDR, CMP, DONE states)
- `done`  out  1  one-cycle completion pulse
- `hit`  out  1  result: a hold contains the query point
- `hit_index`  out  ADDR_BITS  result: index of containing hold; 0 on miss

## Operation
- FSM states: IDLE, ADDR, CMP, DONE. Index counter `i`.
- IDLE:
  - On `start`=1: latch `query_x`/`query_y`, set `i`=0 and `hold_addr`=0, then go to ADDR.
  - Otherwise hold in IDLE.
- ADDR: `hold_addr`=`i` stable; table read in flight. Next state: CMP.
- CMP: sample `hold_x`, `hold_y`, `hold_en`.
  - Hit condition: `hold_en` && `hold_x` ≤ qx < `hold_x`+`WIDTH` && `hold_y` ≤ qy < `hold_y`+`HEIGHT`.
  - On hit: register `hit`=1 and `hit_index`=`i`, then go to DONE (early exit).
  - On miss with `i`=`NUM_HOLDS`-1: register `hit`=0 and `hit_index`=0, then go to DONE.
  - On miss otherwise: `i`+1, `hold_addr`=`i`+1, then go to ADDR.
- DONE: `done`=1 for this cycle only. Next state: IDLE.
- Arithmetic: all compares signed. Sign-extend x terms to 12 bits and y terms to 13 bits before adding `WIDTH`/`HEIGHT`, so no wrap at the +1023 / +2047 extremes.
- Priority: the first (lowest-index) hit wins. Overlapping holds never produce a higher index.
- `start` while `busy`: ignored, with no effect on the latched query or results.
- `hit`/`hit_index` hold their value from the DONE cycle until the next DONE. They are unchanged during a subsequent scan.

## Timing
- Reset values: state IDLE, `i`=0, `hold_addr`=0, `busy`=0, `done`=0, `hit`=0, `hit_index`=0.
- Cycle numbering starts with `start` sampled in IDLE at cycle 0.
- Hit at index k:
  - ADDR at cycle 2k+1, CMP at cycle 2k+2.
  - `done`=1 with valid results at cycle 2k+3.
- Full miss: `done` at cycle 2·`NUM_HOLDS`+1.
- `busy`=1 from cycle 1 through the DONE cycle inclusive. It is 0 in the cycle after `done`.
- The earliest next accepted `start` is the cycle after DONE.
- Table contract: `hold_*` inputs reflect the `hold_addr` registered at the previous edge. The block never samples table data in ADDR.
- Reset asserted mid-scan: immediately return to reset values, with no `done` pulse. The previous result is lost.
- Reset deasserted with `start`=1: `start` is sampled at the first rising edge after release.

## Test plan
- Single hold, hit: `NUM_HOLDS`=16, only hold 3 enabled at (100,200); query (120,210) -> `done` at cycle 9, `hit`=1, `hit_index`=3, `busy` high cycles 1–9.
- Edge cases, hold 0 at (100,200):
  - Queries (147,219) and (100,200) -> hit at cycle 3.
  - Queries (148,210), (99,210), (120,220) and (120,199) -> miss, `done` at cycle 33, `hit`=0, `hit_index`=0.
- Overlap: holds 2 and 5 both contain (300,400) -> `hit_index`=2, `done` at cycle 7. The same query with hold 2 disabled -> `hit_index`=5, `done` at cycle 13.
- Signed range:
  - Hold at (-30,-10), query (-1,5) -> hit.
  - Hold at (1000,2040), query (1023,2047) -> hit, showing no overflow wrap.
  - Hold at (-1024,-2048), query (1023,0) -> miss.
- Handshake: pulse `start` again at cycles 4 and 9 of a running scan with a different query -> ignored. Results match the first query, and there is exactly one `done`.
- Reset mid-scan: assert `reset` at cycle 10 of a miss scan -> `busy`/`done`/`hit`/`hit_index`/`hold_addr` all 0 in the same cycle, and no `done` follows. A fresh `start` after release completes normally.
